// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types for the two-requester round-robin mux arbiter.
//   state_t         : arbiter FSM states
//   sel_t           : mux select encodings (also used for the last-grant pointer)
//   burst_cnt_width : bits needed to hold a burst count of 0..max_burst
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_t;

  function automatic int unsigned burst_cnt_width(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mux2_burst_counter.sv
// Burst-length counter for the arbiter.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : start a new burst (count -> 1), wins over inc
//   inc       : grant held another cycle (saturates at MAX_BURST)
//   at_max_c  : count has reached MAX_BURST
module mux2_burst_counter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic at_max_c
);

  localparam int unsigned CW = burst_cnt_width(MAX_BURST);

  logic [CW-1:0] cnt;

  assign at_max_c = (cnt == CW'(MAX_BURST));

  // Count register: load restarts a burst, inc advances until saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(1);
    end else if (inc && !at_max_c) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 mux, with bursts
// capped at MAX_BURST consecutive grant cycles.
//   clk, rst        : clock, synchronous active-high reset
//   req_a, req_b    : requests
//   data_a, data_b  : mux data inputs
//   gnt_a, gnt_b    : registered grants (one-hot or none)
//   sel             : registered mux select (0 = A, 1 = B), held while idle
//   z               : combinational mux output selected by sel
//   z_valid         : registered, high while either grant is high
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic data_a,
  input  logic data_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic z,
  output logic z_valid
);

  state_t state;
  state_t state_nxt;
  sel_t   sel_q;
  sel_t   last_grant;
  logic   cnt_load_c;
  logic   cnt_inc_c;
  logic   at_max_c;

  mux2_burst_counter #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_c),
    .inc      (cnt_inc_c),
    .at_max_c (at_max_c)
  );

  // Next-state logic; every entry into a grant state (including re-entry
  // after a saturated burst) restarts the burst counter.
  always_comb begin
    state_nxt  = state;
    cnt_load_c = 1'b0;
    cnt_inc_c  = 1'b0;
    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          state_nxt  = (last_grant == SEL_B) ? GNT_A : GNT_B;
          cnt_load_c = 1'b1;
        end else if (req_a) begin
          state_nxt  = GNT_A;
          cnt_load_c = 1'b1;
        end else if (req_b) begin
          state_nxt  = GNT_B;
          cnt_load_c = 1'b1;
        end
      end
      GNT_A: begin
        if (req_a && !at_max_c) begin
          cnt_inc_c = 1'b1;
        end else if (req_b) begin
          state_nxt  = GNT_B;
          cnt_load_c = 1'b1;
        end else if (req_a) begin
          cnt_load_c = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      GNT_B: begin
        if (req_b && !at_max_c) begin
          cnt_inc_c = 1'b1;
        end else if (req_a) begin
          state_nxt  = GNT_A;
          cnt_load_c = 1'b1;
        end else if (req_b) begin
          cnt_load_c = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs and round-robin pointer, decoded from the next state
  // so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      z_valid    <= 1'b0;
      sel_q      <= SEL_A;
      last_grant <= SEL_B;
    end else begin
      gnt_a   <= (state_nxt == GNT_A);
      gnt_b   <= (state_nxt == GNT_B);
      z_valid <= (state_nxt != IDLE);
      if (state_nxt == GNT_A) begin
        sel_q      <= SEL_A;
        last_grant <= SEL_A;
      end else if (state_nxt == GNT_B) begin
        sel_q      <= SEL_B;
        last_grant <= SEL_B;
      end
    end
  end

  assign sel = sel_q;
  assign z   = (sel_q == SEL_B) ? data_b : data_a;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: one instance with MAX_BURST=4, one with
// MAX_BURST=1, sharing stimulus and checked against a grant-ownership model.
module tb_mux2_rr_arbiter;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic req_a  = 1'b0;
  logic req_b  = 1'b0;
  logic data_a = 1'b0;
  logic data_b = 1'b0;

  // index 0: MAX_BURST=4, index 1: MAX_BURST=1
  logic [1:0] gnt_a, gnt_b, sel, z, z_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .gnt_a(gnt_a[0]), .gnt_b(gnt_b[0]), .sel(sel[0]), .z(z[0]), .z_valid(z_valid[0])
  );

  mux2_rr_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .gnt_a(gnt_a[1]), .gnt_b(gnt_b[1]), .sel(sel[1]), .z(z[1]), .z_valid(z_valid[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the mux (0 none, 1 A, 2 B), how long they have held it,
  // who was granted last, and the select value.
  int m_hold[2] = '{0, 0};
  int m_run[2]  = '{0, 0};
  int m_ptr[2]  = '{2, 2};
  int m_sel[2]  = '{0, 0};
  int m_max[2]  = '{4, 1};

  task automatic model_step(input int i);
    logic mine, other;
    if (rst) begin
      m_hold[i] = 0;
      m_run[i]  = 0;
      m_ptr[i]  = 2;
      m_sel[i]  = 0;
    end else begin
      if (m_hold[i] == 0) begin
        if (req_a && req_b)  m_hold[i] = (m_ptr[i] == 1) ? 2 : 1;
        else if (req_a)      m_hold[i] = 1;
        else if (req_b)      m_hold[i] = 2;
        m_run[i] = 1;
      end else begin
        mine  = (m_hold[i] == 1) ? req_a : req_b;
        other = (m_hold[i] == 1) ? req_b : req_a;
        if (mine && m_run[i] < m_max[i]) begin
          m_run[i]++;
        end else if (other) begin
          m_hold[i] = 3 - m_hold[i];
          m_run[i]  = 1;
        end else if (mine) begin
          m_run[i] = 1;
        end else begin
          m_hold[i] = 0;
        end
      end
      if (m_hold[i] != 0) begin
        m_ptr[i] = m_hold[i];
        m_sel[i] = m_hold[i] - 1;
      end
    end
  endtask

  // Advance the model at each edge, then compare every output shortly after.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("gnt_a[%0d]", i),   int'(gnt_a[i]),   int'(m_hold[i] == 1));
      chk($sformatf("gnt_b[%0d]", i),   int'(gnt_b[i]),   int'(m_hold[i] == 2));
      chk($sformatf("sel[%0d]", i),     int'(sel[i]),     m_sel[i]);
      chk($sformatf("z_valid[%0d]", i), int'(z_valid[i]), int'(m_hold[i] != 0));
      chk($sformatf("z[%0d]", i),       int'(z[i]),       int'(m_sel[i] != 0 ? data_b : data_a));
      chk($sformatf("one_hot[%0d]", i), int'(gnt_a[i] & gnt_b[i]), 0);
    end
  end

  // Drive one cycle of inputs at the falling edge, then wait past the rising edge.
  task automatic step(input logic ra, input logic rb, input logic da,
                      input logic db, input logic r);
    @(negedge clk);
    rst    = r;
    req_a  = ra;
    req_b  = rb;
    data_a = da;
    data_b = db;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held with both requesting: nothing granted.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("rst_gnt_a", int'(gnt_a[0]), 0);
      chk("rst_gnt_b", int'(gnt_b[0]), 0);
      chk("rst_sel", int'(sel[0]), 0);
      chk("rst_z_valid", int'(z_valid[0]), 0);
    end

    // Single requester A for 10 cycles: continuous grant across re-entries.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("single_gnt_a", int'(gnt_a[0]), 1);
      chk("single_z", int'(z[0]), 1);
      chk("single_sel", int'(sel[0]), 0);
      chk("single1_gnt_a", int'(gnt_a[1]), 1);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("single_release", int'(gnt_a[0]), 0);
    chk("single_release_valid", int'(z_valid[0]), 0);

    // Dual requests for 16 cycles: AAAABBBB... (MAX 4) and ABAB... (MAX 1).
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("dual4_gnt_a", int'(gnt_a[0]), int'(((k / 4) % 2) == 0));
      chk("dual4_gnt_b", int'(gnt_b[0]), int'(((k / 4) % 2) == 1));
      chk("dual4_sel", int'(sel[0]), (k / 4) % 2);
      chk("dual4_z", int'(z[0]), int'(((k / 4) % 2) == 0));
      chk("dual1_gnt_a", int'(gnt_a[1]), int'((k % 2) == 0));
      chk("dual1_z", int'(z[1]), int'((k % 2) == 0));
    end

    // Early release: A granted 2 cycles, then drops with B waiting.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("early_gnt_a", int'(gnt_a[0]), 1);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("early_gnt_b", int'(gnt_b[0]), 1);
    chk("early_gnt_a_off", int'(gnt_a[0]), 0);
    chk("early_sel", int'(sel[0]), 1);
    chk("early_z", int'(z[0]), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("early_z_follow", int'(z[0]), 0);

    // Reset mid-burst of B, then both requesting: A wins first.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("midrst_gnt_b", int'(gnt_b[0]), 1);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("midrst_gnt_a_rst", int'(gnt_a[0]), 0);
    chk("midrst_gnt_b_rst", int'(gnt_b[0]), 0);
    chk("midrst_sel_rst", int'(sel[0]), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("midrst_gnt_a_first", int'(gnt_a[0]), 1);
    chk("midrst_gnt_b_first", int'(gnt_b[0]), 0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("final_idle", int'(z_valid[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
